// File: rtl/vecmat_operand_packer.sv
// rtl/vecmat_operand_packer.sv - double-buffered element-pair packer for the 32-lane vector-matrix MAC path
//
// Purpose:
//   Collects {vector, matrix} element pairs one per cycle and packs them into
//   ELEM_W*LANES-bit operand words, lane k at bits [k*ELEM_W +: ELEM_W]. Two banks
//   ping-pong: one fills while the other is held for the consumer. A word
//   closes after LANES elements or early on in_last; unused lanes read zero.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   element pair present
//   in_ready   out  packer accepts an element pair this cycle
//   in_vec     in   vector element
//   in_mat     in   matrix element
//   in_last    in   final element of a short word
//   out_valid  out  packed word pair available
//   out_ready  in   consumer takes the word pair this cycle
//   out_vector out  packed vector operand
//   out_matrix out  packed matrix operand
//   out_count  out  number of valid lanes in the word (1..LANES)

module vecmat_operand_packer #(
  parameter  int ELEM_W    = 16,
  parameter  int LANES     = 32,
  localparam int ARRAYSIZE = ELEM_W * LANES,
  localparam int CNT_W     = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ELEM_W-1:0]    in_vec,
  input  logic [ELEM_W-1:0]    in_mat,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ARRAYSIZE-1:0] out_vector,
  output logic [ARRAYSIZE-1:0] out_matrix,
  output logic [CNT_W-1:0]     out_count
);

  localparam int LANE_W = $clog2(LANES);
  localparam int OFF_W  = $clog2(ARRAYSIZE);

  logic [ARRAYSIZE-1:0] vec_bank [2];
  logic [ARRAYSIZE-1:0] mat_bank [2];
  logic [CNT_W-1:0]     cnt_bank [2];
  logic [1:0]           full;
  logic                 wr_sel;
  logic                 rd_sel;
  logic                 rdy_en;
  logic [LANE_W-1:0]    lane_cnt;

  logic                 accept;
  logic                 consume;
  logic                 word_done;
  logic [OFF_W-1:0]     lane_base;

  // in_ready depends only on registered state, so out_ready never reaches it
  // combinationally; a freed bank shows up one cycle after the consume edge.
  assign in_ready   = rdy_en & ~full[wr_sel];
  assign out_valid  = full[rd_sel];
  assign out_vector = vec_bank[rd_sel];
  assign out_matrix = mat_bank[rd_sel];
  assign out_count  = cnt_bank[rd_sel];

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign word_done = accept & ((lane_cnt == LANE_W'(LANES - 1)) | in_last);
  assign lane_base = OFF_W'(lane_cnt) * OFF_W'(ELEM_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en   <= 1'b0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      lane_cnt <= '0;
      full     <= '0;
      for (int b = 0; b < 2; b++) begin
        vec_bank[b] <= '0;
        mat_bank[b] <= '0;
        cnt_bank[b] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;

      // accept needs ~full[wr_sel] and consume needs full[rd_sel], so in any
      // cycle where both fire they address different banks.
      for (int b = 0; b < 2; b++) begin
        if (consume && (rd_sel == 1'(b))) begin
          // Clearing on release keeps lanes beyond a short word at zero
          // when this bank is refilled.
          vec_bank[b] <= '0;
          mat_bank[b] <= '0;
          cnt_bank[b] <= '0;
          full[b]     <= 1'b0;
        end else if (accept && (wr_sel == 1'(b))) begin
          vec_bank[b][lane_base +: ELEM_W] <= in_vec;
          mat_bank[b][lane_base +: ELEM_W] <= in_mat;
          if (word_done) begin
            full[b]     <= 1'b1;
            cnt_bank[b] <= CNT_W'(lane_cnt) + CNT_W'(1);
          end
        end
      end

      if (accept) begin
        if (word_done) begin
          lane_cnt <= '0;
          wr_sel   <= ~wr_sel;
        end else begin
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
      end

      if (consume) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_vecmat_operand_packer.sv
// tb/tb_vecmat_operand_packer.sv - directed and random checks of vecmat_operand_packer
//
// Purpose:
//   Drives element pairs into vecmat_operand_packer and checks the packed
//   words, counts, handshake timing, backpressure, reset discard and ordering.
//
// Ports:
//   none (top-level bench)

module tb_vecmat_operand_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_vec = '0;
  logic [15:0]  in_mat = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_vector;
  logic [511:0] out_matrix;
  logic [5:0]   out_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] mon_vec [$];
  logic [511:0] mon_mat [$];
  logic [5:0]   mon_cnt [$];

  always #5 clk = ~clk;

  vecmat_operand_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .in_mat     (in_mat),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .out_matrix (out_matrix),
    .out_count  (out_count)
  );

  // Inputs change 1ns after the rising edge, so the falling edge sees the
  // handshake values that the next rising edge will act on.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      mon_vec.push_back(out_vector);
      mon_mat.push_back(out_matrix);
      mon_cnt.push_back(out_count);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [15:0] m, input logic l);
    int g = 0;
    in_valid = 1'b1;
    in_vec   = v;
    in_mat   = m;
    in_last  = l;
    while (!in_ready && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) chk("push_timeout_in_ready", 512'(in_ready), 512'(1));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    int g = 0;
    while (mon_vec.size() < n && g < 300) begin
      tick();
      g++;
    end
    chk(tag, 512'(mon_vec.size()), 512'(n));
  endtask

  task automatic check_word(input string tag, input logic [511:0] ev,
                            input logic [511:0] em, input logic [5:0] ec);
    if (mon_vec.size() > 0) begin
      chk($sformatf("%s_vec", tag), mon_vec.pop_front(), ev);
      chk($sformatf("%s_mat", tag), mon_mat.pop_front(), em);
      chk($sformatf("%s_cnt", tag), 512'(mon_cnt.pop_front()), 512'(ec));
    end else begin
      chk($sformatf("%s_present", tag), 512'(mon_vec.size()), 512'(1));
    end
  endtask

  logic [511:0] ev, em, ev2, em2, snap;
  logic [511:0] cv, cm;
  logic [511:0] exp_vec [$];
  logic [511:0] exp_mat [$];
  logic [5:0]   exp_cnt [$];
  int           drops, lane, sent, cyc, n_exp;
  logic         acc;

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid",  512'(out_valid), 512'(0));
    chk("rst_out_count",  512'(out_count), 512'(0));
    chk("rst_out_vector", out_vector, 512'(0));
    chk("rst_out_matrix", out_matrix, 512'(0));
    chk("rst_in_ready",   512'(in_ready), 512'(0));
    reset = 1'b1;
    chk("rel_in_ready_pre_edge", 512'(in_ready), 512'(0));
    tick();
    chk("rel_in_ready_post_edge", 512'(in_ready), 512'(1));

    // 1. Full word
    out_ready = 1'b1;
    for (int k = 0; k < 31; k++) push(16'(k + 1), 16'h0100, 1'b0);
    chk("t1_not_early", 512'(out_valid), 512'(0));
    push(16'd32, 16'h0100, 1'b0);
    chk("t1_valid_after_32nd", 512'(out_valid), 512'(1));
    chk("t1_live_count", 512'(out_count), 512'(32));
    for (int k = 0; k < 32; k++) begin
      ev[k*16 +: 16] = 16'(k + 1);
      em[k*16 +: 16] = 16'h0100;
    end
    wait_words("t1_words", 1);
    check_word("t1", ev, em, 6'd32);

    // 2. Short words, then a shorter word reusing the bank that held t1
    for (int k = 0; k < 5; k++) push(16'h7FFF, 16'hA5A5, (k == 4));
    ev = '0; em = '0;
    for (int k = 0; k < 5; k++) begin
      ev[k*16 +: 16] = 16'h7FFF;
      em[k*16 +: 16] = 16'hA5A5;
    end
    wait_words("t2a_words", 1);
    check_word("t2a", ev, em, 6'd5);
    for (int k = 0; k < 3; k++) push(16'(16'h0010 + k), 16'(16'h0020 + k), (k == 2));
    ev = '0; em = '0;
    for (int k = 0; k < 3; k++) begin
      ev[k*16 +: 16] = 16'(16'h0010 + k);
      em[k*16 +: 16] = 16'(16'h0020 + k);
    end
    wait_words("t2b_words", 1);
    check_word("t2b", ev, em, 6'd3);

    // 3. Backpressure: fill both banks
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 64; k++) push(16'(16'h1000 + k), 16'(16'h2000 + k), 1'b0);
    chk("t3_in_ready_low", 512'(in_ready), 512'(0));
    chk("t3_out_valid", 512'(out_valid), 512'(1));
    snap = out_vector;
    repeat (5) tick();
    chk("t3_stable_vec", out_vector, snap);
    chk("t3_stable_cnt", 512'(out_count), 512'(32));
    chk("t3_no_word_yet", 512'(mon_vec.size()), 512'(0));
    out_ready = 1'b1;
    chk("t3_no_comb_path", 512'(in_ready), 512'(0));
    tick();
    chk("t3_ready_after_consume", 512'(in_ready), 512'(1));
    for (int k = 0; k < 32; k++) begin
      ev[k*16 +: 16]  = 16'(16'h1000 + k);
      em[k*16 +: 16]  = 16'(16'h2000 + k);
      ev2[k*16 +: 16] = 16'(16'h1020 + k);
      em2[k*16 +: 16] = 16'(16'h2020 + k);
    end
    wait_words("t3_words", 2);
    check_word("t3_w0", ev, em, 6'd32);
    check_word("t3_w1", ev2, em2, 6'd32);

    // 4. Sustained streaming
    drops = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      in_vec = 16'(i);
      in_mat = ~16'(i);
      if (!in_ready) drops++;
      tick();
    end
    in_valid = 1'b0;
    chk("t4_in_ready_drops", 512'(drops), 512'(0));
    wait_words("t4_words", 10);
    repeat (5) tick();
    chk("t4_exactly_10", 512'(mon_vec.size()), 512'(10));
    for (int w = 0; w < 10; w++) begin
      for (int k = 0; k < 32; k++) begin
        ev[k*16 +: 16] = 16'(w * 32 + k);
        em[k*16 +: 16] = ~16'(w * 32 + k);
      end
      check_word($sformatf("t4_w%0d", w), ev, em, 6'd32);
    end

    // 5. Reset mid-fill
    for (int k = 0; k < 17; k++) push(16'(16'h3000 + k), 16'(16'h4000 + k), 1'b0);
    reset = 1'b0;
    tick();
    chk("t5_rst_out_valid", 512'(out_valid), 512'(0));
    chk("t5_rst_in_ready", 512'(in_ready), 512'(0));
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) push(16'(16'h5000 + k), 16'(16'h6000 + k), 1'b0);
    for (int k = 0; k < 32; k++) begin
      ev[k*16 +: 16] = 16'(16'h5000 + k);
      em[k*16 +: 16] = 16'(16'h6000 + k);
    end
    wait_words("t5_words", 1);
    check_word("t5", ev, em, 6'd32);
    repeat (5) tick();
    chk("t5_no_extra_word", 512'(mon_vec.size()), 512'(0));

    // 6. Random gaps and random out_ready against a reference packer
    cv = '0; cm = '0; lane = 0; sent = 0; cyc = 0;
    while (sent < 100 && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_vec   = 16'($urandom);
        in_mat   = 16'($urandom);
        in_last  = (sent == 99) || ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        cv[lane*16 +: 16] = in_vec;
        cm[lane*16 +: 16] = in_mat;
        if (lane == 31 || in_last) begin
          exp_vec.push_back(cv);
          exp_mat.push_back(cm);
          exp_cnt.push_back(6'(lane + 1));
          cv = '0; cm = '0; lane = 0;
        end else begin
          lane++;
        end
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    chk("t6_all_sent", 512'(sent), 512'(100));
    n_exp = exp_vec.size();
    wait_words("t6_words", n_exp);
    for (int w = 0; w < n_exp; w++) begin
      check_word($sformatf("t6_w%0d", w), exp_vec[w], exp_mat[w], exp_cnt[w]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
